vector_mem_seq: RTL and testbench

Vector load/store sequencer in the memory stage, directly downstream of the ALU. For VLD/VST the ALU produces the 16-bit effective address (base + offset) on `result[15:0]`; this block takes that address and moves one 256-bit vector, as 16 lanes of 16 bits, over a 16-bit synchronous data-memory port, one lane per cycle. Loaded vectors go to vector-register writeback; stores are taken from the vector register read port.

---
 rtl/vector_mem_seq.sv | 153 +++++++++++++++
 tb/tb_vector_mem_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_seq.sv
// Vector load/store sequencer: moves one LANES x 16-bit vector over a 16-bit memory port, one lane per cycle.
// Optional feature macro: VMEM_STRIDE_EN adds the stride port (per-lane address increment instead of 1).

module vector_mem_seq #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_store,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LANES*16-1:0] store_data,
`ifdef VMEM_STRIDE_EN
    input  logic [ADDR_W-1:0]   stride,
`endif
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [15:0]         mem_wdata,
    input  logic [15:0]         mem_rdata,
    output logic                busy,
    output logic                done,
    output logic [LANES*16-1:0] load_data
);

    localparam int VEC_W = LANES * 16;
    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LTAIL,
        STORE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [VEC_W-1:0]  store_q, store_d;
    logic [VEC_W-1:0]  shadow_q, shadow_d;
    logic [VEC_W-1:0]  load_q, load_d;
    logic [ADDR_W-1:0] inc;

`ifdef VMEM_STRIDE_EN
    logic [ADDR_W-1:0] stride_q, stride_d;

    assign inc = stride_q;
`else
    assign inc = ADDR_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            addr_q   <= '0;
            store_q  <= '0;
            shadow_q <= '0;
            load_q   <= '0;
`ifdef VMEM_STRIDE_EN
            stride_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            shadow_q <= shadow_d;
            load_q   <= load_d;
`ifdef VMEM_STRIDE_EN
            stride_q <= stride_d;
`endif
        end
    end

    // Lane data is shifted: store lanes leave from the bottom, load lanes enter at the top,
    // so after 16 shifts lane 0 ends up in bits [15:0] without any wide lane multiplexer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        store_d   = store_q;
        shadow_d  = shadow_q;
        load_d    = load_q;
`ifdef VMEM_STRIDE_EN
        stride_d  = stride_q;
`endif
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    idx_d   = '0;
                    addr_d  = base_addr;
                    store_d = store_data;
`ifdef VMEM_STRIDE_EN
                    stride_d = stride;
`endif
                    state_d = is_store ? STORE : LOAD;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = addr_q;
                idx_d    = idx_q + IDX_W'(1);
                addr_d   = addr_q + inc;
                if (idx_q != '0) begin
                    shadow_d = {mem_rdata, shadow_q[VEC_W-1:16]};
                end
                if (idx_q == LAST_IDX) begin
                    state_d = LTAIL;
                end
            end
            LTAIL: begin
                busy     = 1'b1;
                shadow_d = {mem_rdata, shadow_q[VEC_W-1:16]};
                load_d   = {mem_rdata, shadow_q[VEC_W-1:16]};
                state_d  = DONE;
            end
            STORE: begin
                busy      = 1'b1;
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = store_q[15:0];
                store_d   = store_q >> 16;
                idx_d     = idx_q + IDX_W'(1);
                addr_d    = addr_q + inc;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign load_data = load_q;

endmodule

// File: tb/tb_vector_mem_seq.sv
// Scoreboard bench for vector_mem_seq: a memory model serves the port, a reference model predicts
// every access and completion, and a monitor compares them as the DUT presents them.

module tb_vector_mem_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_store;
    logic [15:0]  base_addr;
    logic [255:0] store_data;
`ifdef VMEM_STRIDE_EN
    logic [15:0]  stride;
`endif
    logic         mem_en;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata = '0;
    logic         busy;
    logic         done;
    logic [255:0] load_data;

    typedef struct {
        int          cyc;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } accT;

    typedef struct {
        int           cyc;
        logic [255:0] data;
    } doneT;

    accT          accQ[$];
    doneT         doneQ[$];
    accT          accItem;
    doneT         doneItem;
    logic [15:0]  mem    [0:65535];
    logic [15:0]  refMem [0:65535];
    logic [255:0] lastLoad = '0;
    int           cycleCnt = 0;
    int           checks   = 0;
    int           failures = 0;

    vector_mem_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .base_addr  (base_addr),
        .store_data (store_data),
`ifdef VMEM_STRIDE_EN
        .stride     (stride),
`endif
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Synchronous memory: read data appears the cycle after the read is issued.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every access and every done pulse must match the head of its expectation queue.
    always @(negedge clk) begin
        if (mem_we && !mem_en) begin
            checks++;
            failures++;
            $display("[TB] FAIL we_without_en: got mem_we=1 mem_en=0 expected mem_we=0 at cycle %0d", cycleCnt);
        end
        if (mem_en) begin
            if (accQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_access: got addr %h we %b expected none at cycle %0d",
                         mem_addr, mem_we, cycleCnt);
            end else begin
                accItem = accQ.pop_front();
                checkOutput("access {cyc,we,addr,wdata}",
                            {cycleCnt, mem_we, mem_addr, (mem_we ? mem_wdata : 16'h0)},
                            {accItem.cyc, accItem.we, accItem.addr, accItem.wdata});
            end
        end
        if (done) begin
            if (doneQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: got done=1 expected 0 at cycle %0d", cycleCnt);
            end else begin
                doneItem = doneQ.pop_front();
                checkOutput("done {cyc,load_data}", {cycleCnt, load_data}, {doneItem.cyc, doneItem.data});
            end
        end
    end

    task automatic waitCycle(input int cyc);
        while (cycleCnt < cyc) @(negedge clk);
    endtask

    // Issues one operation at the current negedge and records what the DUT must do in response.
    task automatic applyStimulus(input bit st, input logic [15:0] base, input logic [255:0] data,
                                 input logic [15:0] strd, input int nAcc, input bit expectDone,
                                 output int c0);
        logic [15:0]  inc;
        logic [15:0]  a;
        logic [255:0] expVec;
        accT          item;
        doneT         dItem;
        c0         = cycleCnt;
        start      = 1'b1;
        is_store   = st;
        base_addr  = base;
        store_data = data;
`ifdef VMEM_STRIDE_EN
        stride     = strd;
        inc        = strd;
`else
        inc        = 16'd1;
`endif
        for (int i = 0; i < nAcc; i++) begin
            a          = base + 16'(i) * inc;
            item.cyc   = c0 + 1 + i;
            item.we    = st;
            item.addr  = a;
            item.wdata = st ? data[i*16 +: 16] : 16'h0;
            accQ.push_back(item);
            if (st) refMem[a] = data[i*16 +: 16];
        end
        if (expectDone) begin
            if (!st) begin
                for (int i = 0; i < 16; i++) begin
                    a = base + 16'(i) * inc;
                    expVec[i*16 +: 16] = refMem[a];
                end
                lastLoad = expVec;
            end
            dItem.cyc  = c0 + (st ? 17 : 18);
            dItem.data = lastLoad;
            doneQ.push_back(dItem);
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_cycle1", {319'h0, busy}, 320'h1);
    endtask

    function automatic logic [255:0] randVec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        int           c0;
        int           c1;
        int           badWords;
        logic [15:0]  v;
        logic [255:0] d;
        bit           st;
        bit           b2b;
        logic [15:0]  strd;

        rst        = 1'b1;
        start      = 1'b0;
        is_store   = 1'b0;
        base_addr  = '0;
        store_data = '0;
`ifdef VMEM_STRIDE_EN
        stride     = 16'd1;
`endif
        for (int a = 0; a < 65536; a++) begin
            v         = 16'($urandom);
            mem[a]    = v;
            refMem[a] = v;
        end
        repeat (3) @(negedge clk);
        checkOutput("reset mem_en",    {319'h0, mem_en}, 320'h0);
        checkOutput("reset mem_we",    {319'h0, mem_we}, 320'h0);
        checkOutput("reset busy",      {319'h0, busy},   320'h0);
        checkOutput("reset done",      {319'h0, done},   320'h0);
        checkOutput("reset mem_addr",  {304'h0, mem_addr},  320'h0);
        checkOutput("reset mem_wdata", {304'h0, mem_wdata}, 320'h0);
        checkOutput("reset load_data", {64'h0, load_data},  320'h0);
        rst = 1'b0;
        @(negedge clk);

        // Unit-stride load of a known pattern.
        for (int i = 0; i < 16; i++) begin
            mem[16'h0100 + i]    = 16'hA000 + 16'(i);
            refMem[16'h0100 + i] = 16'hA000 + 16'(i);
        end
        applyStimulus(1'b0, 16'h0100, '0, 16'd1, 16, 1'b1, c0);
        waitCycle(c0 + 18);
        checkOutput("load lane0",  {304'h0, load_data[15:0]},    {304'h0, 16'hA000});
        checkOutput("load lane15", {304'h0, load_data[255:240]}, {304'h0, 16'hA00F});
        @(negedge clk);

        // Store with read-back through the memory model.
        for (int i = 0; i < 16; i++) d[i*16 +: 16] = 16'h5A00 + 16'(i);
        applyStimulus(1'b1, 16'h0200, d, 16'd1, 16, 1'b1, c0);
        waitCycle(c0 + 17);
        @(negedge clk);
        for (int i = 0; i < 16; i++)
            checkOutput("store readback", {304'h0, mem[16'h0200 + i]}, {304'h0, 16'h5A00 + 16'(i)});

        // Address wrap from 0xFFFF to 0x0000.
        applyStimulus(1'b0, 16'hFFFC, '0, 16'd1, 16, 1'b1, c0);
        waitCycle(c0 + 18);
        checkOutput("wrap lane4", {304'h0, load_data[79:64]}, {304'h0, refMem[0]});
        @(negedge clk);

        // Starts while busy are ignored; a start in the DONE cycle is taken without a bubble.
        applyStimulus(1'b0, 16'h0300, '0, 16'd1, 16, 1'b1, c0);
        waitCycle(c0 + 5);
        start = 1'b1; is_store = 1'b1; base_addr = 16'h0400; store_data = randVec();
        @(negedge clk);
        start = 1'b0;
        waitCycle(c0 + 10);
        start = 1'b1; is_store = 1'b0; base_addr = 16'h0500;
        @(negedge clk);
        start = 1'b0;
        waitCycle(c0 + 18);
        applyStimulus(1'b1, 16'h0600, randVec(), 16'd1, 16, 1'b1, c1);
        waitCycle(c1 + 17);
        @(negedge clk);

        // Reset in the middle of a store: lanes 0-6 land, nothing after.
        applyStimulus(1'b1, 16'h0700, randVec(), 16'd1, 7, 1'b0, c0);
        waitCycle(c0 + 7);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort mem_en",    {319'h0, mem_en}, 320'h0);
        checkOutput("abort mem_we",    {319'h0, mem_we}, 320'h0);
        checkOutput("abort busy",      {319'h0, busy},   320'h0);
        checkOutput("abort done",      {319'h0, done},   320'h0);
        checkOutput("abort load_data", {64'h0, load_data}, 320'h0);
        lastLoad = '0;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++)
            checkOutput("abort readback", {304'h0, mem[16'h0700 + i]}, {304'h0, refMem[16'h0700 + i]});
        applyStimulus(1'b0, 16'h0100, '0, 16'd1, 16, 1'b1, c0);
        waitCycle(c0 + 18);
        @(negedge clk);

`ifdef VMEM_STRIDE_EN
        applyStimulus(1'b0, 16'h1000, '0, 16'h0010, 16, 1'b1, c0);
        waitCycle(c0 + 18);
        @(negedge clk);
        d = randVec();
        applyStimulus(1'b1, 16'h3000, d, 16'h0000, 16, 1'b1, c0);
        waitCycle(c0 + 17);
        @(negedge clk);
        checkOutput("stride0 last wins", {304'h0, mem[16'h3000]}, {304'h0, d[255:240]});
`endif

        // Randomized operations, some issued back-to-back from the DONE cycle.
        for (int r = 0; r < 14; r++) begin
            st   = 1'($urandom);
            b2b  = 1'($urandom);
`ifdef VMEM_STRIDE_EN
            case ($urandom_range(0, 2))
                0:       strd = 16'd1;
                1:       strd = 16'd0;
                default: strd = 16'($urandom);
            endcase
`else
            strd = 16'd1;
`endif
            applyStimulus(st, 16'($urandom), randVec(), strd, 16, 1'b1, c0);
            waitCycle(c0 + (st ? 17 : 18));
            if (!b2b) @(negedge clk);
        end

        repeat (25) @(negedge clk);
        checkOutput("pending accesses", {288'h0, 32'(accQ.size())},  320'h0);
        checkOutput("pending dones",    {288'h0, 32'(doneQ.size())}, 320'h0);
        badWords = 0;
        for (int a = 0; a < 65536; a++)
            if (mem[a] !== refMem[a]) badWords++;
        checkOutput("memory image mismatching words", {288'h0, 32'(badWords)}, 320'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
